multicycle_control: RTL and testbench

- Parametrised multi-cycle main control unit for the 64-bit RISC-V datapath. It is the successor to the single-cycle opcode decoder.
- Sequences each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB states.
- Handshakes with a shared instruction/data memory via mem_ready, counts retired instructions, and traps on illegal opcodes or memory timeout.

---
 rtl/multicycle_control_if.sv | 33 +++
 rtl/multicycle_control.sv | 176 +++++++++++++++++
 tb/tb_multicycle_control.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control/memory handshake bundle for multicycle_control.
// master: the control unit (drives controls, status); slave: datapath/memory side.
interface multicycle_control_if #(
    parameter int RETIRE_W = 32
);
    logic [6:0]          Opc;
    logic                mem_ready;
    logic                PCWrite;
    logic                IRWrite;
    logic                IorD;
    logic                ALUsrc;
    logic                MemToReg;
    logic                RegWrite;
    logic                MemRead;
    logic                MemWrite;
    logic                Branch;
    logic [1:0]          AluOp;
    logic [RETIRE_W-1:0] retired;
    logic                trap;
    logic [1:0]          trap_cause;

    modport master (
        input  Opc, mem_ready,
        output PCWrite, IRWrite, IorD, ALUsrc, MemToReg, RegWrite,
               MemRead, MemWrite, Branch, AluOp, retired, trap, trap_cause
    );

    modport slave (
        output Opc, mem_ready,
        input  PCWrite, IRWrite, IorD, ALUsrc, MemToReg, RegWrite,
               MemRead, MemWrite, Branch, AluOp, retired, trap, trap_cause
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle main control unit for the 64-bit RISC-V datapath.
// Sequences IDLE/FETCH/DECODE/EXEC/MEM/WB, counts retired instructions and
// traps (sticky) on illegal opcodes or a memory access that never completes.
// Optional build macro MULTICYCLE_CONTROL_ITYPE_EN adds I-type ALU (0010011).
module multicycle_control #(
    parameter int RETIRE_W = 32,
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_control_if.master    bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_R, C_LD, C_SD, C_BEQ, C_ITYPE, C_ILLEGAL
    } class_t;

    state_t              state_q, state_d;
    class_t              class_q, class_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                trap_q, trap_d;
    logic [1:0]          cause_q, cause_d;
    logic                wait_hit;

    function automatic class_t decode_opc(input logic [6:0] opc);
        case (opc)
            7'b0110011: return C_R;
            7'b0000011: return C_LD;
            7'b0100011: return C_SD;
            7'b1100011: return C_BEQ;
`ifdef MULTICYCLE_CONTROL_ITYPE_EN
            7'b0010011: return C_ITYPE;
`endif
            default:    return C_ILLEGAL;
        endcase
    endfunction

    // Last permitted wait cycle: the counter would reach MAX_WAIT this cycle.
    assign wait_hit = (MAX_WAIT != 0) && (wait_q == WAIT_W'(MAX_WAIT - 1));

    // State, class, wait counter, retire counter and trap registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            class_q   <= C_NONE;
            wait_q    <= '0;
            retired_q <= '0;
            trap_q    <= 1'b0;
            cause_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
        end
    end

    // Next-state logic plus Moore decode of state/class (FETCH handshake aside).
    always_comb begin
        state_d      = state_q;
        class_d      = class_q;
        wait_d       = wait_q;
        retired_d    = retired_q;
        trap_d       = trap_q;
        cause_d      = cause_q;
        bus.PCWrite  = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.IorD     = 1'b0;
        bus.ALUsrc   = 1'b0;
        bus.MemToReg = 1'b0;
        bus.RegWrite = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.Branch   = 1'b0;
        bus.AluOp    = 2'b00;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                bus.MemRead = 1'b1;
                if (bus.mem_ready) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    state_d     = S_DECODE;
                end else if (wait_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end
            end
            S_DECODE: begin
                class_d = decode_opc(bus.Opc);
                if (class_d == C_ILLEGAL) begin
                    state_d = S_TRAP;
                    cause_d = 2'b01;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (class_q)
                    C_R: begin
                        bus.AluOp = 2'b10;
                        state_d   = S_WB;
                    end
                    C_ITYPE: begin
                        bus.ALUsrc = 1'b1;
                        bus.AluOp  = 2'b10;
                        state_d    = S_WB;
                    end
                    C_LD, C_SD: begin
                        bus.ALUsrc = 1'b1;
                        state_d    = S_MEM;
                    end
                    C_BEQ: begin
                        bus.AluOp  = 2'b01;
                        bus.Branch = 1'b1;
                        state_d    = S_FETCH;
                        retired_d  = retired_q + RETIRE_W'(1);
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                bus.IorD     = 1'b1;
                bus.ALUsrc   = 1'b1;
                bus.MemRead  = (class_q == C_LD);
                bus.MemWrite = (class_q == C_SD);
                if (bus.mem_ready) begin
                    if (class_q == C_LD) begin
                        state_d = S_WB;
                    end else begin
                        state_d   = S_FETCH;
                        retired_d = retired_q + RETIRE_W'(1);
                    end
                end else if (wait_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end
            end
            S_WB: begin
                bus.RegWrite = 1'b1;
                bus.MemToReg = (class_q == C_LD);
                state_d      = S_FETCH;
                retired_d    = retired_q + RETIRE_W'(1);
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_TRAP) begin
            trap_d = 1'b1;
        end

        // Fresh count on every state change; saturate rather than wrap when
        // the timeout is disabled.
        if (state_d != state_q) begin
            wait_d = '0;
        end else if ((state_q == S_FETCH || state_q == S_MEM) && !bus.mem_ready
                     && wait_q != '1) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    assign bus.retired    = retired_q;
    assign bus.trap       = trap_q;
    assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (RETIRE_W=4 build so the retire
// counter wraps within a short run).
module tb_multicycle_control;

    localparam int RW = 4;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_SD  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_BAD = 7'b1111111;

    // {PCWrite,IRWrite,IorD,ALUsrc,MemToReg,RegWrite,MemRead,MemWrite,Branch,AluOp}
    localparam logic [10:0] C_ZERO     = 11'b00000000000;
    localparam logic [10:0] C_FETCH_RD = 11'b11000010000;
    localparam logic [10:0] C_FETCH_WT = 11'b00000010000;
    localparam logic [10:0] C_EXEC_R   = 11'b00000000010;
    localparam logic [10:0] C_EXEC_LS  = 11'b00010000000;
    localparam logic [10:0] C_EXEC_BEQ = 11'b00000000101;
    localparam logic [10:0] C_EXEC_I   = 11'b00010000010;
    localparam logic [10:0] C_MEM_LD   = 11'b00110010000;
    localparam logic [10:0] C_MEM_SD   = 11'b00110001000;
    localparam logic [10:0] C_WB_LD    = 11'b00001100000;
    localparam logic [10:0] C_WB_R     = 11'b00000100000;

    logic        clk;
    logic        rst_n;
    logic [10:0] ctl;
    int          n_assert = 0;
    int          n_fail   = 0;

    multicycle_control_if #(.RETIRE_W(RW)) bus ();

    multicycle_control #(.RETIRE_W(RW), .WAIT_W(4), .MAX_WAIT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign ctl = {bus.PCWrite, bus.IRWrite, bus.IorD, bus.ALUsrc, bus.MemToReg,
                  bus.RegWrite, bus.MemRead, bus.MemWrite, bus.Branch, bus.AluOp};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the middle of the next cycle, apply mem_ready, let logic settle.
    task automatic step(input logic rdy);
        @(negedge clk);
        bus.mem_ready = rdy;
        #1;
    endtask

    // Assert reset, check cleared state, release it; DUT sits in IDLE afterwards.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ctl", 32'(ctl), 32'(C_ZERO));
        chk("rst_trap", 32'(bus.trap), 32'd0);
        chk("rst_cause", 32'(bus.trap_cause), 32'd0);
        chk("rst_retired", 32'(bus.retired), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_ctl", 32'(ctl), 32'(C_ZERO));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.Opc = 7'd0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // R-type, zero-wait memory
        bus.Opc = OPC_R;
        step(1); chk("r_fetch", 32'(ctl), 32'(C_FETCH_RD));
        step(1); chk("r_decode", 32'(ctl), 32'(C_ZERO));
        step(1); chk("r_exec", 32'(ctl), 32'(C_EXEC_R));
        step(1); chk("r_wb", 32'(ctl), 32'(C_WB_R));
        chk("r_ret_before", 32'(bus.retired), 32'd0);
        step(1); chk("r_ret_after", 32'(bus.retired), 32'd1);
        chk("r_back_fetch", 32'(ctl), 32'(C_FETCH_RD));

        // LD with three wait cycles in MEM
        bus.Opc = OPC_LD;
        step(1); chk("ld_decode", 32'(ctl), 32'(C_ZERO));
        step(0); chk("ld_exec", 32'(ctl), 32'(C_EXEC_LS));
        for (int i = 0; i < 3; i++) begin
            step(0); chk("ld_mem_wait", 32'(ctl), 32'(C_MEM_LD));
        end
        step(1); chk("ld_mem_done", 32'(ctl), 32'(C_MEM_LD));
        step(1); chk("ld_wb", 32'(ctl), 32'(C_WB_LD));
        chk("ld_ret_before", 32'(bus.retired), 32'd1);
        step(1); chk("ld_ret_after", 32'(bus.retired), 32'd2);
        chk("ld_back_fetch", 32'(ctl), 32'(C_FETCH_RD));

        // SD then BEQ
        bus.Opc = OPC_SD;
        step(1); chk("sd_decode", 32'(ctl), 32'(C_ZERO));
        step(1); chk("sd_exec", 32'(ctl), 32'(C_EXEC_LS));
        step(1); chk("sd_mem", 32'(ctl), 32'(C_MEM_SD));
        step(1); chk("sd_ret", 32'(bus.retired), 32'd3);
        chk("sd_back_fetch", 32'(ctl), 32'(C_FETCH_RD));
        bus.Opc = OPC_BEQ;
        step(1); chk("beq_decode", 32'(ctl), 32'(C_ZERO));
        step(1); chk("beq_exec", 32'(ctl), 32'(C_EXEC_BEQ));
        step(1); chk("beq_ret", 32'(bus.retired), 32'd4);
        chk("beq_back_fetch", 32'(ctl), 32'(C_FETCH_RD));

        // I-type: optional class
        bus.Opc = OPC_I;
        step(1); chk("i_decode", 32'(ctl), 32'(C_ZERO));
`ifdef MULTICYCLE_CONTROL_ITYPE_EN
        step(1); chk("i_exec", 32'(ctl), 32'(C_EXEC_I));
        step(1); chk("i_wb", 32'(ctl), 32'(C_WB_R));
        step(1); chk("i_ret", 32'(bus.retired), 32'd5);
        chk("i_trap", 32'(bus.trap), 32'd0);
`else
        step(1); chk("i_trap_ctl", 32'(ctl), 32'(C_ZERO));
        chk("i_trap", 32'(bus.trap), 32'd1);
        chk("i_cause", 32'(bus.trap_cause), 32'd1);
        chk("i_ret", 32'(bus.retired), 32'd4);
`endif

        // Illegal opcode: sticky trap until reset
        do_reset();
        bus.Opc = OPC_BAD;
        step(1); chk("ill_fetch", 32'(ctl), 32'(C_FETCH_RD));
        step(1); chk("ill_decode", 32'(ctl), 32'(C_ZERO));
        for (int i = 0; i < 20; i++) begin
            step(logic'(i % 2));
            chk("ill_ctl", 32'(ctl), 32'(C_ZERO));
            chk("ill_trap", 32'(bus.trap), 32'd1);
            chk("ill_cause", 32'(bus.trap_cause), 32'd1);
        end

        // Fetch timeout: 15 wait cycles then TRAP
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            step(0);
            chk("to_fetch_wait", 32'(ctl), 32'(C_FETCH_WT));
            chk("to_no_trap", 32'(bus.trap), 32'd0);
        end
        step(0);
        chk("to_trap", 32'(bus.trap), 32'd1);
        chk("to_cause", 32'(bus.trap_cause), 32'd2);
        chk("to_ctl", 32'(ctl), 32'(C_ZERO));

        // mem_ready on the 15th cycle wins; then BEQs until retired wraps
        do_reset();
        bus.Opc = OPC_BEQ;
        for (int k = 1; k <= 14; k++) begin
            step(0);
            chk("late_fetch_wait", 32'(ctl), 32'(C_FETCH_WT));
        end
        step(1); chk("late_fetch_rdy", 32'(ctl), 32'(C_FETCH_RD));
        step(0); chk("late_decode", 32'(ctl), 32'(C_ZERO));
        chk("late_no_trap", 32'(bus.trap), 32'd0);
        step(0); chk("late_exec", 32'(ctl), 32'(C_EXEC_BEQ));
        step(1); chk("wrap_ret1", 32'(bus.retired), 32'd1);
        for (int n = 2; n <= 16; n++) begin
            step(1);
            step(1);
            step(1);
            chk("wrap_ret", 32'(bus.retired), 32'(n % 16));
        end
        chk("wrap_trap", 32'(bus.trap), 32'd0);

        // Asynchronous abort: MemRead drops without a clock edge
        do_reset();
        step(0); chk("abort_fetch", 32'(ctl), 32'(C_FETCH_WT));
        rst_n = 1'b0;
        #1;
        chk("abort_ctl", 32'(ctl), 32'(C_ZERO));
        chk("abort_ret", 32'(bus.retired), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
